// File: rtl/io_port_responder.sv
`default_nettype none
// ============================================================================
// io_port_responder: device-side responder for CPU port SEND/RECV requests,
// queueing host messages in a FIFO and stalling RECVs until the host answers.
// Revision: 1.0
// ============================================================================
module io_port_responder #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cpu_req,
    input  logic              cpu_dir,
    input  logic [DATA_W-1:0] cpu_port,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_result,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_kind,
    output logic [DATA_W-1:0] tx_port,
    output logic [DATA_W-1:0] tx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_halt,
    output logic              halted
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_RX = 2'd1,
        ACK     = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                halted_q, halted_d;
    logic [DATA_W-1:0]   result_q, result_d;

    logic                fifo_kind_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_port_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];

    logic                w_full;
    logic                w_accept;
    logic                w_pop;

    // Push eligibility uses the registered count, so a full FIFO blocks a
    // push even when the host pops in the same cycle.
    always_comb begin
        w_full   = (count_q == CNT_W'(FIFO_DEPTH));
        w_accept = (state_q == IDLE) && cpu_req && !halted_q && !w_full;
        w_pop    = (count_q != '0) && tx_ready;

        state_d  = state_q;
        halted_d = halted_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d = cpu_dir ? ACK : WAIT_RX;
                end
            end
            WAIT_RX: begin
                if (rx_valid) begin
                    state_d = ACK;
                    if (rx_halt) begin
                        halted_d = 1'b1;
                        result_d = '0;
                    end else begin
                        result_d = rx_data;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        wr_ptr_d = wr_ptr_q + PTR_W'(w_accept);
        rd_ptr_d = rd_ptr_q + PTR_W'(w_pop);
        count_d  = count_q + CNT_W'(w_accept) - CNT_W'(w_pop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            halted_q <= halted_d;
            result_q <= result_d;
        end
    end

    // Payload storage needs no reset: the head outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            fifo_kind_q[wr_ptr_q] <= cpu_dir;
            fifo_port_q[wr_ptr_q] <= cpu_port;
            fifo_data_q[wr_ptr_q] <= cpu_dir ? cpu_data : '0;
        end
    end

    assign cpu_ack    = (state_q == ACK);
    assign rx_ready   = (state_q == WAIT_RX);
    assign cpu_result = result_q;
    assign halted     = halted_q;
    assign tx_valid   = (count_q != '0);
    assign tx_kind    = tx_valid ? fifo_kind_q[rd_ptr_q] : 1'b0;
    assign tx_port    = tx_valid ? fifo_port_q[rd_ptr_q] : '0;
    assign tx_data    = tx_valid ? fifo_data_q[rd_ptr_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_io_port_responder.sv
`default_nettype none
// ============================================================================
// tb_io_port_responder: directed vector table plus hand-written sequences
// for FIFO full, ordering, stray responses, halt and async reset.
// Revision: 1.0
// ============================================================================
module tb_io_port_responder;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              cpu_req = 1'b0;
    logic              cpu_dir = 1'b0;
    logic [DATA_W-1:0] cpu_port = '0;
    logic [DATA_W-1:0] cpu_data = '0;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_result;
    logic              tx_valid;
    logic              tx_ready = 1'b0;
    logic              tx_kind;
    logic [DATA_W-1:0] tx_port;
    logic [DATA_W-1:0] tx_data;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic [DATA_W-1:0] rx_data = '0;
    logic              rx_halt = 1'b0;
    logic              halted;

    always #5 clk = ~clk;

    io_port_responder #(.DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cpu_req    (cpu_req),
        .cpu_dir    (cpu_dir),
        .cpu_port   (cpu_port),
        .cpu_data   (cpu_data),
        .cpu_ack    (cpu_ack),
        .cpu_result (cpu_result),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_kind    (tx_kind),
        .tx_port    (tx_port),
        .tx_data    (tx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_halt    (rx_halt),
        .halted     (halted)
    );

    typedef struct {
        logic              dir;
        logic [DATA_W-1:0] port;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] rx;
        logic              exp_kind;
        logic [DATA_W-1:0] exp_port;
        logic [DATA_W-1:0] exp_data;
        logic [DATA_W-1:0] exp_result;
    } vec_t;

    vec_t vecs [6];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_txn(input logic [DATA_W-1:0] p, input logic [DATA_W-1:0] d,
                            input string name);
        bit got;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_dir  = 1'b1;
        cpu_port = p;
        cpu_data = d;
        wait_ack(6, got);
        chk(name, got, 1);
        cpu_req = 1'b0;
    endtask

    // One full transaction with an empty FIFO: exact-latency checks on the
    // head message, the ack and the result.
    task automatic do_vec(input vec_t v, input string tag);
        @(negedge clk);
        tx_ready = 1'b0;
        cpu_req  = 1'b1;
        cpu_dir  = v.dir;
        cpu_port = v.port;
        cpu_data = v.data;
        @(negedge clk);
        chk($sformatf("%s_tx_valid", tag), tx_valid, 1);
        chk($sformatf("%s_tx_kind", tag), tx_kind, v.exp_kind);
        chk($sformatf("%s_tx_port", tag), tx_port, v.exp_port);
        chk($sformatf("%s_tx_data", tag), tx_data, v.exp_data);
        if (v.dir) begin
            chk($sformatf("%s_ack", tag), cpu_ack, 1);
            chk($sformatf("%s_result", tag), cpu_result, v.exp_result);
            cpu_req  = 1'b0;
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
            chk($sformatf("%s_ack_drop", tag), cpu_ack, 0);
            chk($sformatf("%s_drained", tag), tx_valid, 0);
        end else begin
            chk($sformatf("%s_no_ack", tag), cpu_ack, 0);
            chk($sformatf("%s_rx_ready", tag), rx_ready, 1);
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
            chk($sformatf("%s_drained", tag), tx_valid, 0);
            rx_valid = 1'b1;
            rx_data  = v.rx;
            @(negedge clk);
            rx_valid = 1'b0;
            chk($sformatf("%s_ack", tag), cpu_ack, 1);
            chk($sformatf("%s_result", tag), cpu_result, v.exp_result);
            cpu_req = 1'b0;
            @(negedge clk);
            chk($sformatf("%s_ack_drop", tag), cpu_ack, 0);
            chk($sformatf("%s_rx_ready_drop", tag), rx_ready, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit   got;
        bit   stall_ok;
        vec_t v;

        vecs[0] = '{1'b1, 16'd3,    16'd42,   16'h0000, 1'b1, 16'd3,    16'd42,   16'h0000};
        vecs[1] = '{1'b0, 16'd7,    16'hBEEF, 16'h1234, 1'b0, 16'd7,    16'h0000, 16'h1234};
        vecs[2] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFF, 16'h1234};
        vecs[3] = '{1'b0, 16'h0000, 16'h5555, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 16'hFFFF};
        vecs[4] = '{1'b1, 16'd1,    16'h0000, 16'h0000, 1'b1, 16'd1,    16'h0000, 16'hFFFF};
        vecs[5] = '{1'b0, 16'h8000, 16'h0001, 16'h0000, 1'b0, 16'h8000, 16'h0000, 16'h0000};

        repeat (2) @(negedge clk);
        chk("rst_ack", cpu_ack, 0);
        chk("rst_result", cpu_result, 0);
        chk("rst_halted", halted, 0);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_fields", {tx_kind, tx_port, tx_data}, 0);
        rstn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Stray host response while idle must not be captured
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 16'd5;
        chk("stray_rx_ready", rx_ready, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        v = '{1'b0, 16'd4, 16'd0, 16'd1, 1'b0, 16'd4, 16'd0, 16'd1};
        do_vec(v, "stray_recv");

        // FIFO full: four SENDs fill it, the fifth waits for a pop
        tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send_txn(16'd10, 16'(i), $sformatf("fill_send%0d", i));
        end
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_dir  = 1'b1;
        cpu_port = 16'd10;
        cpu_data = 16'd5;
        wait_ack(5, got);
        chk("full_blocks_ack", got, 0);
        chk("full_head", tx_data, 1);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        wait_ack(3, got);
        chk("full_after_pop_ack", got, 1);
        cpu_req = 1'b0;
        for (int j = 2; j <= 5; j++) begin
            chk($sformatf("full_order%0d", j), tx_data, j);
            chk($sformatf("full_port%0d", j), tx_port, 10);
            tx_ready = 1'b1;
            @(negedge clk);
        end
        tx_ready = 1'b0;
        chk("full_drained", tx_valid, 0);

        // SEND then RECV: host sees the SEND first, answers late
        send_txn(16'd7, 16'd9, "ord_send");
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_dir  = 1'b0;
        cpu_port = 16'd7;
        cpu_data = 16'h3333;
        @(negedge clk);
        chk("ord_rx_ready", rx_ready, 1);
        chk("ord_head0", {tx_kind, tx_port, tx_data}, {1'b1, 16'd7, 16'd9});
        tx_ready = 1'b1;
        @(negedge clk);
        chk("ord_head1", {tx_kind, tx_port, tx_data}, {1'b0, 16'd7, 16'd0});
        @(negedge clk);
        tx_ready = 1'b0;
        chk("ord_drained", tx_valid, 0);
        stall_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!rx_ready || cpu_ack) stall_ok = 1'b0;
        end
        chk("ord_stall", stall_ok, 1);
        rx_valid = 1'b1;
        rx_data  = 16'h1234;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("ord_ack", cpu_ack, 1);
        chk("ord_result", cpu_result, 16'h1234);
        chk("ord_rx_ready_drop", rx_ready, 0);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("ord_ack_drop", cpu_ack, 0);

        // Halt: RECV answered with rx_halt, later SEND never acked, queue drains
        send_txn(16'd2, 16'h0077, "halt_pre_send");
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_dir  = 1'b0;
        cpu_port = 16'd5;
        @(negedge clk);
        chk("halt_rx_ready", rx_ready, 1);
        rx_valid = 1'b1;
        rx_halt  = 1'b1;
        rx_data  = 16'hDEAD;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_halt  = 1'b0;
        chk("halt_ack", cpu_ack, 1);
        chk("halt_result", cpu_result, 0);
        chk("halt_flag", halted, 1);
        cpu_req = 1'b0;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_dir  = 1'b1;
        cpu_port = 16'd9;
        cpu_data = 16'd9;
        wait_ack(8, got);
        chk("halt_send_blocked", got, 0);
        chk("halt_head0", {tx_kind, tx_port, tx_data}, {1'b1, 16'd2, 16'h0077});
        tx_ready = 1'b1;
        @(negedge clk);
        chk("halt_head1", {tx_kind, tx_port, tx_data}, {1'b0, 16'd5, 16'd0});
        @(negedge clk);
        chk("halt_drained", tx_valid, 0);
        tx_ready = 1'b0;
        cpu_req  = 1'b0;
        chk("halt_sticky", halted, 1);

        // Async reset in WAIT_RX with two messages queued
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("rst2_halted", halted, 0);
        v = '{1'b0, 16'd6, 16'd0, 16'hABCD, 1'b0, 16'd6, 16'd0, 16'hABCD};
        do_vec(v, "pre_rst_recv");
        send_txn(16'd1, 16'd2, "pre_rst_send");
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_dir  = 1'b0;
        cpu_port = 16'd3;
        @(negedge clk);
        chk("pre_rst_wait", rx_ready, 1);
        chk("pre_rst_queued", tx_valid, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_tx_valid", tx_valid, 0);
        chk("arst_rx_ready", rx_ready, 0);
        chk("arst_ack", cpu_ack, 0);
        chk("arst_result", cpu_result, 0);
        chk("arst_tx_fields", {tx_kind, tx_port, tx_data}, 0);
        @(negedge clk);
        cpu_req = 1'b0;
        rstn    = 1'b1;
        v = '{1'b1, 16'd11, 16'd22, 16'd0, 1'b1, 16'd11, 16'd22, 16'd0};
        do_vec(v, "post_rst_send");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
